uart_port: RTL

Memory-mapped UART peripheral for the pipelined CPU's data-memory path. It is the device end of the rdn/wrn/data_ready/tbre/tsre strobe-and-status interface that `dm` drives. It converts bus strobes into 8N1 serial frames on `Txd` and deserializes `Rxd` into a readable byte, reporting status back to the core. It sits on the board beside Ram1 and shares the low byte of the Ram1 data bus.

---
 rtl/uart_port.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_port.sv
// Memory-mapped 8N1 UART for the dm strobe/status interface (rdn/wrn/tbre/tsre/data_ready).
// Define UART_RX_FIFO_EN for an RX_DEPTH-entry receive FIFO; otherwise a single holding register.
module uart_port #(
    parameter int CLKS_PER_BIT = 96,
    parameter int RX_DEPTH     = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       rdn,
    input  logic       wrn,
    inout  wire  [7:0] Bus_data,
    output logic       data_ready,
    output logic       tbre,
    output logic       tsre,
    output logic       rx_overrun,
    output logic       Txd,
    input  logic       Rxd
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] bitLast = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] midLast = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

    logic [1:0] wrnSync, rdnSync;
    logic       wrnPrev, rdnPrev;
    logic       wrEdge, rdEdge;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wrnSync <= 2'b11;
            rdnSync <= 2'b11;
            wrnPrev <= 1'b1;
            rdnPrev <= 1'b1;
        end else begin
            wrnSync <= {wrnSync[0], wrn};
            rdnSync <= {rdnSync[0], rdn};
            wrnPrev <= wrnSync[1];
            rdnPrev <= rdnSync[1];
        end
    end

    assign wrEdge = wrnSync[1] & ~wrnPrev;
    assign rdEdge = rdnSync[1] & ~rdnPrev;

    txState_t      txState;
    logic [CW-1:0] txCnt;
    logic [2:0]    txBit;
    logic [7:0]    txShift, thr;
    logic          thrFull;

    assign tbre = ~thrFull;

    // A write needs an empty THR and a load needs a full one, so they never collide.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            txState <= TX_IDLE;
            txCnt   <= '0;
            txBit   <= '0;
            txShift <= '0;
            thr     <= '0;
            thrFull <= 1'b0;
            Txd     <= 1'b1;
            tsre    <= 1'b1;
        end else begin
            if (wrEdge && !thrFull) begin
                thr     <= Bus_data;
                thrFull <= 1'b1;
            end
            case (txState)
                TX_IDLE: begin
                    if (thrFull) begin
                        txShift <= thr;
                        thrFull <= 1'b0;
                        tsre    <= 1'b0;
                        Txd     <= 1'b0;
                        txCnt   <= '0;
                        txState <= TX_START;
                    end
                end
                TX_START: begin
                    if (txCnt == bitLast) begin
                        txCnt   <= '0;
                        txBit   <= '0;
                        Txd     <= txShift[0];
                        txState <= TX_DATA;
                    end else begin
                        txCnt <= txCnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (txCnt == bitLast) begin
                        txCnt <= '0;
                        if (txBit == 3'd7) begin
                            Txd     <= 1'b1;
                            txState <= TX_STOP;
                        end else begin
                            txBit   <= txBit + 1'b1;
                            Txd     <= txShift[1];
                            txShift <= {1'b0, txShift[7:1]};
                        end
                    end else begin
                        txCnt <= txCnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (txCnt == bitLast) begin
                        txCnt <= '0;
                        if (thrFull) begin
                            txShift <= thr;
                            thrFull <= 1'b0;
                            Txd     <= 1'b0;
                            txState <= TX_START;
                        end else begin
                            tsre    <= 1'b1;
                            txState <= TX_IDLE;
                        end
                    end else begin
                        txCnt <= txCnt + 1'b1;
                    end
                end
                default: txState <= TX_IDLE;
            endcase
        end
    end

    rxState_t      rxState;
    logic [1:0]    rxSync;
    logic          rxPrev, rxd;
    logic [CW-1:0] rxCnt;
    logic [2:0]    rxBit;
    logic [7:0]    rxShift;
    logic          rxDeliver;

    assign rxd = rxSync[1];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rxSync    <= 2'b11;
            rxPrev    <= 1'b1;
            rxState   <= RX_IDLE;
            rxCnt     <= '0;
            rxBit     <= '0;
            rxShift   <= '0;
            rxDeliver <= 1'b0;
        end else begin
            rxSync    <= {rxSync[0], Rxd};
            rxPrev    <= rxd;
            rxDeliver <= 1'b0;
            case (rxState)
                RX_IDLE: begin
                    if (rxPrev && !rxd) begin
                        rxCnt   <= '0;
                        rxState <= RX_START;
                    end
                end
                RX_START: begin
                    if (rxCnt == midLast) begin
                        rxCnt   <= '0;
                        rxBit   <= '0;
                        rxState <= rxd ? RX_IDLE : RX_DATA;
                    end else begin
                        rxCnt <= rxCnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rxCnt == bitLast) begin
                        rxCnt   <= '0;
                        rxShift <= {rxd, rxShift[7:1]};
                        if (rxBit == 3'd7) rxState <= RX_STOP;
                        else               rxBit   <= rxBit + 1'b1;
                    end else begin
                        rxCnt <= rxCnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rxCnt == bitLast) begin
                        rxCnt     <= '0;
                        rxDeliver <= rxd;
                        rxState   <= RX_IDLE;
                    end else begin
                        rxCnt <= rxCnt + 1'b1;
                    end
                end
                default: rxState <= RX_IDLE;
            endcase
        end
    end

    logic [7:0] rdData;
    logic       popDo, pushDo;

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(RX_DEPTH);

    logic [7:0] fifoMem [RX_DEPTH];
    logic [AW:0] wrPtr, rdPtr;
    logic [7:0]  lastByte;
    logic        fifoEmpty, fifoFull;

    assign fifoEmpty = (wrPtr == rdPtr);
    assign fifoFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign popDo     = rdEdge && !fifoEmpty;
    // A pop in the same cycle frees the slot the new byte needs.
    assign pushDo    = rxDeliver && (!fifoFull || popDo);
    assign data_ready = !fifoEmpty;
    assign rdData    = fifoEmpty ? lastByte : fifoMem[rdPtr[AW-1:0]];

    always_ff @(posedge Clk) begin
        if (pushDo) fifoMem[wrPtr[AW-1:0]] <= rxShift;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            lastByte   <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (pushDo) wrPtr <= wrPtr + 1'b1;
            if (rxDeliver && !pushDo) rx_overrun <= 1'b1;
            if (popDo) begin
                lastByte <= fifoMem[rdPtr[AW-1:0]];
                rdPtr    <= rdPtr + 1'b1;
            end
        end
    end
`else
    logic       rxValid;
    logic [7:0] holdReg;

    assign popDo      = rdEdge && rxValid;
    assign pushDo     = rxDeliver && (!rxValid || popDo);
    assign data_ready = rxValid;
    assign rdData     = holdReg;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rxValid    <= 1'b0;
            holdReg    <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (popDo) rxValid <= 1'b0;
            if (pushDo) begin
                holdReg <= rxShift;
                rxValid <= 1'b1;
            end
            if (rxDeliver && !pushDo) rx_overrun <= 1'b1;
        end
    end
`endif

    // Output enable uses raw rdn so the bus is released without sync delay.
    assign Bus_data = !rdn ? rdData : 8'bz;

endmodule
